alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequencer/arbiter that shares one 8-bit ALU slice (ports Ain, Bin, Fn, CI -> Result, CO, OV) between two requesters.
Executes NBYTES*8-bit operations as NBYTES byte passes, LSB first, chaining the carry between passes.
The ALU stays outside this block; the controller drives its inputs and samples its outputs.
Returns one tagged result per accepted request over a valid/ready response channel.

Parameters:
ALU_W, 8, ALU slice width in bits.
NBYTES, 2, passes per operation; operand width is DW = ALU_W*NBYTES.

Ports:
Clock  in  1  sole clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
ReqValid  in  2  per-requester request valid.
ReqReady  out  2  per-requester accept, combinational, at most one bit high.
ReqFn0, ReqFn1  in  2 each  op: 00 A+B+CI, 01 A+(B>>>1)+CI, 10 A&B, 11 ~A.
ReqA0, ReqB0, ReqA1, ReqB1  in  DW each  operands.
ReqCI0, ReqCI1  in  1 each  carry-in, used for ops 00 and 01 only.
AluA, AluB  out  ALU_W each  byte slice driven to the ALU.
AluFn  out  2  ALU function.
AluCI  out  1  ALU carry-in.
AluResult  in  ALU_W  ALU result.
AluCO, AluOV  in  1 each  ALU carry-out and overflow.
RspValid  out  1  response valid.
RspReady  in  1  response consumed.
RspId  out  1  index of the requester served.
RspResult  out  DW  assembled result.
RspCO, RspOV  out  1 each  final carry-out and overflow.
Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE.
  - All Rsp* outputs, Busy, AluA, AluB, AluFn and AluCI are 0.
  - Round-robin pointer is cleared so requester 0 has priority.
  - A reset mid-operation abandons the operation; no response is produced.
- States: IDLE -> PASS -> DONE -> IDLE.
- IDLE, arbitration:
  - Winner = the valid requester. If both are valid, the one not served last wins.
  - ReqReady[winner]=1 in the same cycle; the accept happens on that edge.
  - At accept, latch Fn, A, B, CI and Id.
  - For op 01, latch B as the arithmetic shift {B[DW-1], B[DW-1:1]}.
  - Set byte counter k=0 and the pointer to the winner.
- PASS, one cycle per byte k:
  - AluA = A[k] and AluB = B[k] (byte slices).
  - AluFn = 00 for ops 00 and 01, else the latched Fn. The ALU shift path is never used.
  - AluCI = latched CI when k=0, else the CO registered from pass k-1. AluCI = 0 for ops 10 and 11.
  - Each edge stores AluResult into RspResult byte k and registers AluCO.
  - On k=NBYTES-1, capture AluCO/AluOV into RspCO/RspOV, forced to 0 for ops 10 and 11, then go to DONE.
- DONE:
  - RspValid=1; all Rsp* outputs are held stable until RspValid&RspReady.
  - Then go to IDLE. No accepts while in PASS or DONE.
- Latency and throughput:
  - RspValid rises NBYTES edges after the accept edge.
  - If RspReady is held high, one operation completes per NBYTES+2 cycles.
- In IDLE and DONE, Alu* outputs hold their last values. They are don't-care to the bench.
- Wrap-around: the byte counter is ceil(log2(NBYTES)) bits (minimum 1) and never exceeds NBYTES-1.
- Ops 10 and 11: no carry chaining; B is ignored for op 11.

Optional Feature:
ALU_SEQ_STATS_EN:
- When defined, adds two outputs, OpCount[15:0] and OvCount[15:0].
- OpCount increments on each response handshake.
- OvCount increments on a handshake with RspOV=1.
- Both saturate at 0xFFFF and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Req0 op00, A=0x00FF, B=0x0001, CI=0:
  - Pass0 drives AluA=FF, AluB=01, AluCI=0; pass1 drives 00/00, AluCI=1.
  - Response: RspResult=0x0100, CO=0, OV=0, RspId=0, RspValid 2 edges after accept.
- Req1 op00, A=0x7FFF, B=0x0001, CI=0 -> RspResult=0x8000, OV=1, CO=0, RspId=1.
- Req0 op01, A=0x0010, B=0xFFFE, CI=0 -> latched B=0xFFFF, RspResult=0x000F, CO=1, OV=0.
- Arbitration: both requesters valid continuously, RspReady=1, ops 10 (A=0xF0F0, B=0xFF00) and 11 (A=0x1234):
  - Grants alternate 0,1,0,1.
  - Results alternate 0xF000 and 0xEDCB, CO=OV=0.
- Backpressure: RspReady=0 for 5 cycles in DONE:
  - Rsp* outputs are stable and ReqReady=0 throughout.
  - Handshake, then a new accept the following cycle.
- Reset mid-PASS: Reset_n low asynchronously after pass0:
  - Busy=0 and RspValid=0 immediately.
  - Requester 0 wins the next simultaneous request.
  - With ALU_SEQ_STATS_EN, counters read 0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - two-requester sequencer sharing one ALU_W-bit ALU slice over NBYTES chained passes
// Optional feature: define ALU_SEQ_STATS_EN to add OpCount/OvCount response statistics outputs.
module alu_seq_ctrl #(
  parameter int ALU_W  = 8,
  parameter int NBYTES = 2
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [1:0]                ReqValid,
  output logic [1:0]                ReqReady,
  input  logic [1:0]                ReqFn0,
  input  logic [1:0]                ReqFn1,
  input  logic [ALU_W*NBYTES-1:0]   ReqA0,
  input  logic [ALU_W*NBYTES-1:0]   ReqB0,
  input  logic [ALU_W*NBYTES-1:0]   ReqA1,
  input  logic [ALU_W*NBYTES-1:0]   ReqB1,
  input  logic                      ReqCI0,
  input  logic                      ReqCI1,
  output logic [ALU_W-1:0]          AluA,
  output logic [ALU_W-1:0]          AluB,
  output logic [1:0]                AluFn,
  output logic                      AluCI,
  input  logic [ALU_W-1:0]          AluResult,
  input  logic                      AluCO,
  input  logic                      AluOV,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic                      RspId,
  output logic [ALU_W*NBYTES-1:0]   RspResult,
  output logic                      RspCO,
  output logic                      RspOV,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]               OpCount,
  output logic [15:0]               OvCount,
`endif
  output logic                      Busy
);

  localparam int DW = ALU_W * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operands are stored as byte arrays so the pass counter indexes them directly.
  logic [NBYTES-1:0][ALU_W-1:0] r_a;
  logic [NBYTES-1:0][ALU_W-1:0] r_b;
  logic [NBYTES-1:0][ALU_W-1:0] r_result;
  logic [1:0]                   r_fn;
  logic                         r_ci;
  logic                         r_id;
  logic                         r_prio;   // requester that wins a tie
  logic [KW-1:0]                r_k;
  logic                         r_carry;
  logic                         r_co;
  logic                         r_ov;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_accept;
  logic          w_last;
  logic          w_hs;
  logic [1:0]    w_sel_fn;
  logic [DW-1:0] w_sel_a;
  logic [DW-1:0] w_sel_b;
  logic          w_sel_ci;

  // Arbitration and requester operand selection; ties go to r_prio.
  always_comb begin
    w_gnt0   = ReqValid[0] && (!ReqValid[1] || !r_prio);
    w_gnt1   = ReqValid[1] && (!ReqValid[0] ||  r_prio);
    w_accept = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);
    w_last   = (r_k == KW'(NBYTES - 1));
    w_hs     = (r_state == S_DONE) && RspReady;
    w_sel_fn = w_gnt1 ? ReqFn1 : ReqFn0;
    w_sel_a  = w_gnt1 ? ReqA1  : ReqA0;
    w_sel_ci = w_gnt1 ? ReqCI1 : ReqCI0;
    w_sel_b  = w_gnt1 ? ReqB1  : ReqB0;
    // Op 01 pre-shifts B arithmetically so the ALU only ever needs its adder.
    if (w_sel_fn == 2'b01) begin
      w_sel_b = {w_sel_b[DW-1], w_sel_b[DW-1:1]};
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept, walk the bytes, then hold until the response is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_PASS;
      S_PASS:  if (w_last)   w_next = S_DONE;
      S_DONE:  if (w_hs)     w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: ALU drive comes from the latched operands so it holds outside PASS.
  always_comb begin
    ReqReady = 2'b00;
    Busy     = 1'b0;
    RspValid = 1'b0;
    AluA     = r_a[r_k];
    AluB     = r_b[r_k];
    AluFn    = r_fn[1] ? r_fn : 2'b00;
    AluCI    = r_fn[1] ? 1'b0 : ((r_k == '0) ? r_ci : r_carry);
    case (r_state)
      S_IDLE: ReqReady = {w_gnt1, w_gnt0};
      S_PASS: Busy = 1'b1;
      S_DONE: begin
        Busy     = 1'b1;
        RspValid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch the request at accept, collect one result byte per pass.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_fn     <= 2'b00;
      r_ci     <= 1'b0;
      r_id     <= 1'b0;
      r_prio   <= 1'b0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_co     <= 1'b0;
      r_ov     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= w_sel_a;
      r_b     <= w_sel_b;
      r_fn    <= w_sel_fn;
      r_ci    <= w_sel_ci;
      r_id    <= w_gnt1;
      r_prio  <= ~w_gnt1;
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_PASS) begin
      r_result[r_k] <= AluResult;
      if (w_last) begin
        // Logic ops have no meaningful carry or overflow.
        r_co <= r_fn[1] ? 1'b0 : AluCO;
        r_ov <= r_fn[1] ? 1'b0 : AluOV;
      end else begin
        r_carry <= AluCO;
        r_k     <= r_k + KW'(1);
      end
    end
  end

  assign RspId     = r_id;
  assign RspResult = r_result;
  assign RspCO     = r_co;
  assign RspOV     = r_ov;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_op_cnt;
  logic [15:0] r_ov_cnt;

  // Saturating counts of delivered responses and of those reporting overflow.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op_cnt <= 16'h0000;
      r_ov_cnt <= 16'h0000;
    end else if (w_hs) begin
      if (r_op_cnt != 16'hFFFF) r_op_cnt <= r_op_cnt + 16'h0001;
      if (r_ov && (r_ov_cnt != 16'hFFFF)) r_ov_cnt <= r_ov_cnt + 16'h0001;
    end
  end

  assign OpCount = r_op_cnt;
  assign OvCount = r_ov_cnt;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed-vector bench for alu_seq_ctrl with a behavioural 8-bit ALU slice
module tb_alu_seq_ctrl;

  localparam int ALU_W  = 8;
  localparam int NBYTES = 2;
  localparam int DW     = ALU_W * NBYTES;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic [1:0]       ReqValid;
  logic [1:0]       ReqReady;
  logic [1:0]       ReqFn0, ReqFn1;
  logic [DW-1:0]    ReqA0, ReqB0, ReqA1, ReqB1;
  logic             ReqCI0, ReqCI1;
  logic [ALU_W-1:0] AluA, AluB;
  logic [1:0]       AluFn;
  logic             AluCI;
  logic [ALU_W-1:0] AluResult;
  logic             AluCO, AluOV;
  logic             RspValid, RspReady, RspId;
  logic [DW-1:0]    RspResult;
  logic             RspCO, RspOV, Busy;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]      OpCount, OvCount;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  alu_seq_ctrl #(.ALU_W(ALU_W), .NBYTES(NBYTES)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqFn0(ReqFn0), .ReqFn1(ReqFn1),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ReqCI0(ReqCI0), .ReqCI1(ReqCI1),
    .AluA(AluA), .AluB(AluB), .AluFn(AluFn), .AluCI(AluCI),
    .AluResult(AluResult), .AluCO(AluCO), .AluOV(AluOV),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspResult(RspResult), .RspCO(RspCO), .RspOV(RspOV),
`ifdef ALU_SEQ_STATS_EN
    .OpCount(OpCount), .OvCount(OvCount),
`endif
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // External ALU slice: adder with carry/overflow, shift, AND, NOT.
  logic [8:0] s9;
  always_comb begin
    s9        = {1'b0, AluA} + {1'b0, AluB} + {8'h00, AluCI};
    AluResult = 8'h00;
    AluCO     = 1'b0;
    AluOV     = 1'b0;
    case (AluFn)
      2'b00: begin
        AluResult = s9[7:0];
        AluCO     = s9[8];
        AluOV     = (AluA[7] == AluB[7]) && (s9[7] != AluA[7]);
      end
      2'b01: AluResult = {AluA[7], AluA[7:1]};
      2'b10: AluResult = AluA & AluB;
      default: AluResult = ~AluA;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] fn, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
    if (id == 0) begin
      ReqFn0 = fn; ReqA0 = a; ReqB0 = b; ReqCI0 = ci; ReqValid[0] = 1'b1;
    end else begin
      ReqFn1 = fn; ReqA1 = a; ReqB1 = b; ReqCI1 = ci; ReqValid[1] = 1'b1;
    end
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!RspValid && lat < 12) begin
      @(negedge Clock);
      lat++;
    end
    if (!RspValid) check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input int id, input logic [1:0] fn, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic [15:0] exp_res,
                       input logic exp_co, input logic exp_ov, input string tag);
    int n;
    int lat;
    logic [1:0] exp_gnt;
    exp_gnt = (id == 0) ? 2'b01 : 2'b10;
    @(negedge Clock);
    set_req(id, fn, a, b, ci);
    #1;
    n = 0;
    while (!ReqReady[id] && n < 10) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check({tag, "_grant"}, 32'(ReqReady), 32'(exp_gnt));
    @(negedge Clock);
    ReqValid = 2'b00;
    wait_rsp(tag, lat);
    check({tag, "_latency"}, lat, NBYTES);
    check({tag, "_result"}, 32'(RspResult), 32'(exp_res));
    check({tag, "_co"}, 32'(RspCO), 32'(exp_co));
    check({tag, "_ov"}, 32'(RspOV), 32'(exp_ov));
    check({tag, "_id"}, 32'(RspId), id);
    RspReady = 1'b1;
    @(negedge Clock);
    check({tag, "_released"}, 32'(RspValid), 0);
    RspReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int t_prev;
    Reset_n  = 1'b0;
    ReqValid = 2'b00;
    ReqFn0 = 2'b00; ReqFn1 = 2'b00;
    ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0;
    ReqCI0 = 1'b0; ReqCI1 = 1'b0;
    RspReady = 1'b0;
    t_prev = 0;
    repeat (3) @(negedge Clock);
    check("rst_busy", 32'(Busy), 0);
    check("rst_rspvalid", 32'(RspValid), 0);
    check("rst_rspresult", 32'(RspResult), 0);
    check("rst_rsp_flags", 32'({RspId, RspCO, RspOV}), 0);
    check("rst_alu_drive", 32'({AluA, AluB, AluFn, AluCI}), 0);
    Reset_n = 1'b1;

    // Req0 op00 0x00FF + 0x0001, pass-by-pass ALU drive
    @(negedge Clock);
    set_req(0, 2'b00, 16'h00FF, 16'h0001, 1'b0);
    #1;
    check("t1_grant", 32'(ReqReady), 32'h1);
    @(negedge Clock);
    ReqValid = 2'b00;
    check("t1_p0_drive", 32'({AluA, AluB, AluFn, AluCI}), 32'({8'hFF, 8'h01, 2'b00, 1'b0}));
    check("t1_p0_busy_noready", 32'({Busy, ReqReady}), 32'h4);
    @(negedge Clock);
    check("t1_p1_drive", 32'({AluA, AluB, AluFn, AluCI}), 32'({8'h00, 8'h00, 2'b00, 1'b1}));
    check("t1_p1_notvalid", 32'(RspValid), 0);
    @(negedge Clock);
    check("t1_valid", 32'(RspValid), 1);
    check("t1_result", 32'(RspResult), 32'h0100);
    check("t1_co_ov_id", 32'({RspCO, RspOV, RspId}), 0);
    RspReady = 1'b1;
    @(negedge Clock);
    check("t1_released", 32'(RspValid), 0);
    RspReady = 1'b0;

    do_op(0, 2'b01, 16'h0010, 16'hFFFE, 1'b0, 16'h000F, 1'b1, 1'b0, "t3_op01");
    do_op(1, 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t2_ovf");

    // Both requesters held valid with RspReady high: grants must alternate
    @(negedge Clock);
    set_req(0, 2'b10, 16'hF0F0, 16'hFF00, 1'b0);
    set_req(1, 2'b11, 16'h1234, 16'h0000, 1'b1);
    RspReady = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_rsp("arb", lat);
      check("arb_id", 32'(RspId), r % 2);
      check("arb_result", 32'(RspResult), (r % 2 == 1) ? 32'hEDCB : 32'hF000);
      check("arb_co_ov", 32'({RspCO, RspOV}), 0);
      if (r > 0) check("arb_period", cyc - t_prev, NBYTES + 2);
      t_prev = cyc;
      if (r == 3) ReqValid = 2'b00;
      @(negedge Clock);
    end
    RspReady = 1'b0;

    // Backpressure in DONE while requester 1 keeps asking
    @(negedge Clock);
    set_req(0, 2'b10, 16'h00FF, 16'h0F0F, 1'b0);
    set_req(1, 2'b11, 16'h00FF, 16'h0000, 1'b0);
    #1;
    check("bp_grant0", 32'(ReqReady), 32'h1);
    @(negedge Clock);
    ReqValid[0] = 1'b0;
    wait_rsp("bp", lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(RspValid), 1);
      check("bp_hold_result", 32'({RspId, RspCO, RspOV, RspResult}), 32'h000F);
      check("bp_no_ready", 32'(ReqReady), 0);
      @(negedge Clock);
    end
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;
    check("bp_idle_after_hs", 32'({Busy, RspValid}), 0);
    check("bp_next_grant", 32'(ReqReady), 32'h2);
    @(negedge Clock);
    ReqValid = 2'b00;
    check("bp_next_accepted", 32'(Busy), 1);
    wait_rsp("bp2", lat);
    check("bp2_id_result", 32'({RspId, RspResult}), 32'h1FF00);
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;

`ifdef ALU_SEQ_STATS_EN
    check("stats_opcount", 32'(OpCount), 9);
    check("stats_ovcount", 32'(OvCount), 1);
`endif

    // Asynchronous reset after pass0 abandons the operation
    @(negedge Clock);
    set_req(0, 2'b00, 16'h1111, 16'h2222, 1'b0);
    #1;
    check("rstmid_grant", 32'(ReqReady), 32'h1);
    @(negedge Clock);
    ReqValid = 2'b00;
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(Busy), 0);
    check("rstmid_rspvalid", 32'(RspValid), 0);
    check("rstmid_result_clr", 32'(RspResult), 0);
`ifdef ALU_SEQ_STATS_EN
    check("rstmid_stats_clr", 32'({OpCount, OvCount}), 0);
`endif
    set_req(0, 2'b00, 16'h0001, 16'h0001, 1'b0);
    set_req(1, 2'b00, 16'h0005, 16'h0005, 1'b0);
    @(negedge Clock);
    check("rstmid_held", 32'({Busy, RspValid}), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    check("rstmid_prio0", 32'(ReqReady), 32'h1);
    @(negedge Clock);
    ReqValid = 2'b00;
    wait_rsp("rstmid", lat);
    check("rstmid_lat", lat, NBYTES);
    check("rstmid_rsp", 32'({RspId, RspCO, RspOV, RspResult}), 32'h0002);
    RspReady = 1'b1;
    @(negedge Clock);
    RspReady = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
